// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM and
// registers the fetched word (with its PC and fault flag) into the IF/ID outputs.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        if_adel_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        rom_ce_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_inst_q;
    logic        if_valid_q;
    logic        if_adel_q;
    logic [31:0] fetch_cnt_q;

    logic [31:0] pc_seq_d;
    logic        misaligned;

    // Sequential successor; the instruction fetched this cycle is the branch delay slot.
    assign pc_seq_d   = branch_flag_i ? branch_target_i : pc_q + 32'd4;
    assign misaligned = |pc_q[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            rom_ce_q    <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= '0;
            if_valid_q  <= 1'b0;
            if_adel_q   <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= FETCH;
                    rom_ce_q <= 1'b1;
                end

                FETCH: begin
                    if (flush_i) begin
                        pc_q       <= new_pc_i;
                        if_inst_q  <= '0;
                        if_valid_q <= 1'b0;
                        if_adel_q  <= 1'b0;
                    end else if (stall_i) begin
                        pc_q <= pc_q;
                    end else if (misaligned) begin
                        // Fault word is delivered once; ROM is disabled until a flush.
                        state_q    <= FAULT;
                        rom_ce_q   <= 1'b0;
                        if_pc_q    <= pc_q;
                        if_inst_q  <= '0;
                        if_valid_q <= 1'b1;
                        if_adel_q  <= 1'b1;
                    end else begin
                        pc_q        <= pc_seq_d;
                        if_pc_q     <= pc_q;
                        if_inst_q   <= rom_inst_i;
                        if_valid_q  <= 1'b1;
                        if_adel_q   <= 1'b0;
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                    end
                end

                FAULT: begin
                    if_inst_q  <= '0;
                    if_valid_q <= 1'b0;
                    if_adel_q  <= 1'b0;
                    if (flush_i) begin
                        state_q  <= FETCH;
                        rom_ce_q <= 1'b1;
                        pc_q     <= new_pc_i;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    rom_ce_q <= 1'b0;
                end
            endcase
        end
    end

    assign rom_ce_o    = rom_ce_q;
    assign rom_addr_o  = pc_q;
    assign if_pc_o     = if_pc_q;
    assign if_inst_o   = if_inst_q;
    assign if_valid_o  = if_valid_q;
    assign if_adel_o   = if_adel_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a behavioural model predicts every cycle's outputs,
// a monitor compares them one clock later.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        if_adel_o;
    logic [31:0] fetch_cnt_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o),
        .if_adel_o       (if_adel_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Combinational ROM: reads zero while disabled.
    assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic        ce;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
        logic [31:0] cnt;
    } snap_t;

    snap_t exp_q[$];

    // Reference model: mode 0 = waiting after reset, 1 = fetching, 2 = halted on fault.
    int          m_mode;
    logic [31:0] m_pc, m_ifpc, m_inst, m_cnt;
    logic        m_valid, m_adel;

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_ifpc  = 32'h0;
        m_inst  = 32'h0;
        m_valid = 1'b0;
        m_adel  = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_step(input logic r, input logic st, input logic br,
                              input logic [31:0] tgt, input logic fl, input logic [31:0] np);
        if (!r) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (fl) begin
                m_pc = np; m_valid = 0; m_inst = 0; m_adel = 0;
            end else if (!st) begin
                m_ifpc  = m_pc;
                m_valid = 1;
                if ((m_pc % 4) != 0) begin
                    m_inst = 0; m_adel = 1; m_mode = 2;
                end else begin
                    m_inst = rom_word(m_pc);
                    m_adel = 0;
                    m_cnt  = m_cnt + 1;
                    m_pc   = br ? tgt : m_pc + 32'd4;
                end
            end
        end else begin
            m_valid = 0; m_adel = 0; m_inst = 0;
            if (fl) begin
                m_pc = np; m_mode = 1;
            end
        end
    endtask

    task automatic cycle(input logic rn, input logic st, input logic br,
                         input logic [31:0] tgt, input logic fl, input logic [31:0] np);
        snap_t s;
        @(negedge clk);
        rst = rn; stall_i = st; branch_flag_i = br; branch_target_i = tgt;
        flush_i = fl; new_pc_i = np;
        model_step(rn, st, br, tgt, fl, np);
        s.addr = m_pc; s.ce = (m_mode == 1); s.ifpc = m_ifpc; s.inst = m_inst;
        s.valid = m_valid; s.adel = m_adel; s.cnt = m_cnt;
        exp_q.push_back(s);
    endtask

    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic fl, input logic [31:0] np);
        cycle(1'b1, st, br, tgt, fl, np);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".rom_ce"},   {31'h0, rom_ce_o},   32'h0);
        chk({tag, ".rom_addr"}, rom_addr_o,          32'h0);
        chk({tag, ".if_pc"},    if_pc_o,             32'h0);
        chk({tag, ".if_inst"},  if_inst_o,           32'h0);
        chk({tag, ".if_valid"}, {31'h0, if_valid_o}, 32'h0);
        chk({tag, ".if_adel"},  {31'h0, if_adel_o},  32'h0);
        chk({tag, ".cnt"},      fetch_cnt_o,         32'h0);
    endtask

    // Monitor: every cycle's outputs are compared against the oldest prediction.
    always @(posedge clk) begin
        snap_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rom_ce",   {31'h0, rom_ce_o},   {31'h0, e.ce});
            chk("rom_addr", rom_addr_o,          e.addr);
            chk("if_pc",    if_pc_o,             e.ifpc);
            chk("if_inst",  if_inst_o,           e.inst);
            chk("if_valid", {31'h0, if_valid_o}, {31'h0, e.valid});
            chk("if_adel",  {31'h0, if_adel_o},  {31'h0, e.adel});
            chk("fetch_cnt", fetch_cnt_o,        e.cnt);
        end
    end

    initial begin
        rst = 1'b0; stall_i = 0; branch_flag_i = 0; branch_target_i = 0;
        flush_i = 0; new_pc_i = 0;
        model_reset();
        #1;
        chk_reset_values("reset0");
        cycle(1'b0, 0, 0, 32'h0, 0, 32'h0);

        // Release, sequential run, stall at PC=8, branch at PC=12.
        run(3);
        for (int unsigned i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 32'h0);
        run(1);
        step(0, 1, 32'h40, 0, 32'h0);
        run(2);
        step(1, 1, 32'h100, 0, 32'h0);
        run(2);

        // Flush beats stall and branch in the same cycle.
        step(1, 1, 32'h200, 1, 32'h20);
        run(3);

        // Misaligned branch target, fault persists (also under stall) until flush.
        step(0, 1, 32'h42, 0, 32'h0);
        run(2);
        step(1, 0, 32'h0, 0, 32'h0);
        run(2);
        step(0, 0, 32'h0, 1, 32'h80);
        run(3);

        // Randomised traffic.
        for (int unsigned i = 0; i < 400; i++) begin
            logic [31:0] tgt, np;
            tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom % 12 == 0) tgt[1:0] = 2'($urandom);
            np = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom % 12 == 0) np[1:0] = 2'($urandom);
            step(($urandom % 4) == 0, ($urandom % 5) == 0, tgt,
                 ($urandom % 9) == 0, np);
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_values("async_reset");
        model_reset();
        cycle(1'b0, 0, 0, 32'h0, 0, 32'h0);
        run(4);

        // PC wrap past the top of the address space.
        step(0, 0, 32'h0, 1, 32'hFFFF_FFF8);
        run(4);

        @(posedge clk);
        #4;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
